// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multi-digit 7-segment controller with frame-aligned loads, blanking, blink and scan
module seg7_display_ctrl #(
    parameter int DIGITS    = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [4*DIGITS-1:0]   iDIG,
    input  logic [DIGITS-1:0]     iDP_MASK,
    input  logic [DIGITS-1:0]     iBLINK_MASK,
    input  logic                  iBLANK_LZ,
    input  logic                  iLOAD,
    output logic                  oREADY,
    output logic [8*DIGITS-1:0]   oSEG,
    output logic [7:0]            oSCAN_SEG,
    output logic [DIGITS-1:0]     oSCAN_SEL
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [BLK_W-1:0]    r_blk_cnt;
    logic                r_phase;
    logic                r_pending;
    logic                r_ready;
    logic [4*DIGITS-1:0] r_sh_dig;
    logic [DIGITS-1:0]   r_sh_dp;
    logic [DIGITS-1:0]   r_sh_blink;
    logic                r_sh_lz;
    logic [4*DIGITS-1:0] r_act_dig;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_blink;
    logic                r_act_lz;
    logic [8*DIGITS-1:0] r_seg;
    logic [7:0]          r_scan_seg;
    logic [DIGITS-1:0]   r_scan_sel;

    logic                w_div_tc;
    logic                w_frame;
    logic                w_accept;
    logic                w_apply;
    logic                w_pending_n;
    logic                w_blk_tc;
    logic                w_phase_n;
    logic [DIV_W-1:0]    w_div_n;
    logic [IDX_W-1:0]    w_idx_n;
    logic [BLK_W-1:0]    w_blk_n;
    logic [4*DIGITS-1:0] w_act_dig_n;
    logic [DIGITS-1:0]   w_act_dp_n;
    logic [DIGITS-1:0]   w_act_blink_n;
    logic                w_act_lz_n;
    logic [8*DIGITS-1:0] w_code;
    logic [7:0]          w_scan_seg_n;
    logic [DIGITS-1:0]   w_scan_sel_n;
    logic                w_leading;
    logic [3:0]          w_nib;
    logic [7:0]          w_digit;

    always_comb begin
        w_div_tc    = (r_div == DIV_LAST);
        w_frame     = w_div_tc && (r_idx == IDX_LAST);
        w_accept    = iLOAD && r_ready;
        w_apply     = w_frame && r_pending;
        w_pending_n = w_accept || (r_pending && !w_apply);
        w_div_n     = w_div_tc ? '0 : r_div + DIV_W'(1);
        w_idx_n     = r_idx;
        if (w_div_tc) begin
            w_idx_n = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end
        w_blk_tc  = (r_blk_cnt == BLK_LAST);
        w_blk_n   = w_blk_tc ? '0 : r_blk_cnt + BLK_W'(1);
        w_phase_n = r_phase ^ w_blk_tc;
    end

    // Codes are built from next-cycle state so the registered outputs change on the same edge as the active set.
    always_comb begin
        w_act_dig_n   = w_apply ? r_sh_dig   : r_act_dig;
        w_act_dp_n    = w_apply ? r_sh_dp    : r_act_dp;
        w_act_blink_n = w_apply ? r_sh_blink : r_act_blink;
        w_act_lz_n    = w_apply ? r_sh_lz    : r_act_lz;
        w_code        = '0;
        w_leading     = w_act_lz_n;
        w_nib         = '0;
        w_digit       = 8'hFF;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_nib   = w_act_dig_n[4*k +: 4];
            w_digit = hex_to_seg(w_nib);
            if (w_act_dp_n[k]) begin
                w_digit[7] = 1'b0;
            end
            if (w_nib != 4'd0 || w_act_dp_n[k]) begin
                w_leading = 1'b0;
            end
            if (w_leading && k != 0) begin
                w_digit = 8'hFF;
            end
            if (w_phase_n && w_act_blink_n[k]) begin
                w_digit = 8'hFF;
            end
            w_code[8*k +: 8] = w_digit;
        end
    end

    always_comb begin
        w_scan_seg_n = 8'hFF;
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == w_idx_n) begin
                w_scan_seg_n = w_code[8*k +: 8];
            end
        end
        w_scan_sel_n = ~(DIGITS'(1) << w_idx_n);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_div       <= '0;
            r_idx       <= '0;
            r_blk_cnt   <= '0;
            r_phase     <= 1'b0;
            r_pending   <= 1'b0;
            r_ready     <= 1'b1;
            r_sh_dig    <= '0;
            r_sh_dp     <= '0;
            r_sh_blink  <= '0;
            r_sh_lz     <= 1'b0;
            r_act_dig   <= '0;
            r_act_dp    <= '0;
            r_act_blink <= '0;
            r_act_lz    <= 1'b0;
            r_seg       <= {DIGITS{8'hC0}};
            r_scan_seg  <= 8'hC0;
            r_scan_sel  <= ~DIGITS'(1);
        end else begin
            r_div       <= w_div_n;
            r_idx       <= w_idx_n;
            r_blk_cnt   <= w_blk_n;
            r_phase     <= w_phase_n;
            r_pending   <= w_pending_n;
            r_ready     <= !w_pending_n;
            if (w_accept) begin
                r_sh_dig   <= iDIG;
                r_sh_dp    <= iDP_MASK;
                r_sh_blink <= iBLINK_MASK;
                r_sh_lz    <= iBLANK_LZ;
            end
            r_act_dig   <= w_act_dig_n;
            r_act_dp    <= w_act_dp_n;
            r_act_blink <= w_act_blink_n;
            r_act_lz    <= w_act_lz_n;
            r_seg       <= w_code;
            r_scan_seg  <= w_scan_seg_n;
            r_scan_sel  <= w_scan_sel_n;
        end
    end

    assign oREADY    = r_ready;
    assign oSEG      = r_seg;
    assign oSCAN_SEG = r_scan_seg;
    assign oSCAN_SEL = r_scan_sel;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - scoreboard bench for seg7_display_ctrl (DIGITS=6, SCAN_DIV=4, BLINK_DIV=16)
module tb_seg7_display_ctrl;

    logic        iCLK;
    logic        iRST_N;
    logic [23:0] iDIG;
    logic [5:0]  iDP_MASK;
    logic [5:0]  iBLINK_MASK;
    logic        iBLANK_LZ;
    logic        iLOAD;
    logic        oREADY;
    logic [47:0] oSEG;
    logic [7:0]  oSCAN_SEG;
    logic [5:0]  oSCAN_SEL;

    seg7_display_ctrl #(.DIGITS(6), .SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iDIG        (iDIG),
        .iDP_MASK    (iDP_MASK),
        .iBLINK_MASK (iBLINK_MASK),
        .iBLANK_LZ   (iBLANK_LZ),
        .iLOAD       (iLOAD),
        .oREADY      (oREADY),
        .oSEG        (oSEG),
        .oSCAN_SEG   (oSCAN_SEG),
        .oSCAN_SEL   (oSCAN_SEL)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [47:0] seg;
        logic [5:0]  blink;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    exp_t        popped;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        rst_seen = 1'b0;
    int          idx;
    int          phase;
    logic [47:0] exp_seg;
    logic [5:0]  exp_sel;
    logic [7:0]  exp_scan;
    logic        exp_ready;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Reference timeline: edges counted since reset release drive divider, index and blink phase.
    always @(posedge iCLK) begin
        rst_seen <= iRST_N;
        if (!iRST_N) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(negedge iCLK) begin
        if (!rst_seen) begin
            cur.seg   = {6{8'hC0}};
            cur.blink = 6'd0;
            cur.acc   = 0;
        end else if (sb.size() > 0 && (cyc % 24) == 0 && sb[0].acc < cyc) begin
            popped = sb.pop_front();
            chk("apply_latency_ok", 48'((cyc - popped.acc) <= 25 && (cyc - popped.acc) >= 1), 48'd1);
            cur = popped;
        end
        phase   = (cyc / 16) % 2;
        idx     = (cyc / 4) % 6;
        exp_seg = cur.seg;
        for (int k = 0; k < 6; k++) begin
            if (phase == 1 && cur.blink[k]) exp_seg[8*k +: 8] = 8'hFF;
        end
        exp_sel   = ~(6'b000001 << idx);
        exp_scan  = exp_seg[8*idx +: 8];
        exp_ready = rst_seen ? (sb.size() == 0) : 1'b1;
        chk("oSEG", oSEG, exp_seg);
        chk("oSCAN_SEL", 48'(oSCAN_SEL), 48'(exp_sel));
        chk("oSCAN_SEG", 48'(oSCAN_SEG), 48'(exp_scan));
        chk("oREADY", 48'(oREADY), 48'(exp_ready));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout pending=%0d required=0", sb.size());
        end
    endtask

    task automatic do_load(input logic [23:0] dig, input logic [5:0] dp, input logic [5:0] blk,
                           input logic lz, input logic [47:0] seg_exp);
        exp_t e;
        wait_idle();
        iDIG        = dig;
        iDP_MASK    = dp;
        iBLINK_MASK = blk;
        iBLANK_LZ   = lz;
        iLOAD       = 1'b1;
        step(1);
        iLOAD = 1'b0;
        if (sb.size() == 0) begin
            e.seg   = seg_exp;
            e.blink = blk;
            e.acc   = cyc;
            sb.push_back(e);
        end
        iDIG        = 24'($urandom);
        iDP_MASK    = 6'($urandom);
        iBLINK_MASK = 6'($urandom);
        iBLANK_LZ   = 1'($urandom);
    endtask

    initial begin
        iRST_N      = 1'b0;
        iDIG        = '0;
        iDP_MASK    = '0;
        iBLINK_MASK = '0;
        iBLANK_LZ   = 1'b0;
        iLOAD       = 1'b0;
        step(2);
        iRST_N = 1'b1;
        step(10);

        do_load(24'h12AB5F, 6'b000000, 6'b000000, 1'b0, 48'hF9_A4_88_83_92_8E);
        wait_idle();
        step(24);

        do_load(24'h000070, 6'b000000, 6'b000000, 1'b1, 48'hFF_FF_FF_FF_F8_C0);
        do_load(24'h000070, 6'b001000, 6'b000000, 1'b1, 48'hFF_FF_40_C0_F8_C0);
        do_load(24'h000000, 6'b000000, 6'b000000, 1'b1, 48'hFF_FF_FF_FF_FF_C0);

        do_load(24'h000005, 6'b000000, 6'b000001, 1'b0, 48'hC0_C0_C0_C0_C0_92);
        wait_idle();
        step(48);

        do_load(24'h654321, 6'b000000, 6'b000000, 1'b0, 48'h82_92_99_B0_A4_F9);
        iDIG        = 24'hFFFFFF;
        iDP_MASK    = 6'b111111;
        iBLINK_MASK = 6'b000000;
        iLOAD       = 1'b1;
        step(3);
        iLOAD = 1'b0;
        wait_idle();
        step(24);

        do_load(24'h000008, 6'b000001, 6'b000000, 1'b0, 48'hC0_C0_C0_C0_C0_00);
        step(3);
        iRST_N = 1'b0;
        step(1);
        sb.delete();
        step(1);
        iRST_N = 1'b1;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
